// File: rtl/ofm_wr_ctrl_if.sv
// ofm_wr_ctrl_if -- bundle of the output-feature-map write controller signals.
//   start/base_addr/shift/relu_en : map launch and per-map configuration
//   in_valid/in_ready/in_acc      : accumulator stream (valid/ready handshake)
//   sram_ry                       : SRAM ready
//   sram_write_en/addr/wdata      : SRAM write port (write_en active-high)
//   busy/done                     : map status
// master = producer/SRAM side (testbench or parent), slave = the controller.
interface ofm_wr_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 11,
  parameter int ACC_WIDTH  = 20
);
  logic                        start;
  logic [ADDR_BITS-1:0]        base_addr;
  logic [4:0]                  shift;
  logic                        relu_en;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [ACC_WIDTH-1:0] in_acc;
  logic                        sram_ry;
  logic                        sram_write_en;
  logic [ADDR_BITS-1:0]        sram_addr;
  logic [DATA_WIDTH-1:0]       sram_wdata;
  logic                        busy;
  logic                        done;

  modport master (
    output start, base_addr, shift, relu_en, in_valid, in_acc, sram_ry,
    input  in_ready, sram_write_en, sram_addr, sram_wdata, busy, done
  );

  modport slave (
    input  start, base_addr, shift, relu_en, in_valid, in_acc, sram_ry,
    output in_ready, sram_write_en, sram_addr, sram_wdata, busy, done
  );
endinterface

// File: rtl/ofm_wr_ctrl.sv
// ofm_wr_ctrl -- requantises a stream of signed accumulator values and writes
// one map of NUM_PIX words into OFM SRAM starting at base_addr.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ofm_wr_ctrl_if slave (launch/config, accumulator stream, SRAM port,
//         busy/done status)
//
// state | meaning
// IDLE  | waiting for start; no SRAM writes
// RUN   | accepting inputs and issuing one write per accepted input
// DONE  | one-cycle done pulse after the last write; start ignored
module ofm_wr_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 11,
  parameter int ACC_WIDTH  = 20,
  parameter int NUM_PIX    = 784
) (
  input logic         clk,
  input logic         rst,
  ofm_wr_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_PIX + 1);
  localparam logic [CNT_W-1:0] NUM_PIX_C = CNT_W'(NUM_PIX);
  localparam int SAT_MAX_I = (2 ** (DATA_WIDTH - 1)) - 1;
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'(SAT_MAX_I);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = -SAT_MAX - 1;
  localparam logic [ACC_WIDTH:0] RND_ONE = (ACC_WIDTH + 1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_BITS-1:0]   base_q;
  logic [4:0]             shift_q;
  logic                   relu_q;
  logic                   wr_en_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;

  logic                   in_ready_c;
  logic                   accept;
  logic                   last_wr;
  logic signed [ACC_WIDTH:0] rnd, r_sum, r_shr;
  logic [DATA_WIDTH-1:0]  q_val;

  assign accept  = bus.in_valid && in_ready_c;
  // The write registered from the final accept is on the bus this cycle.
  assign last_wr = wr_en_q && (cnt_q == NUM_PIX_C);

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        in_ready_c = bus.sram_ry && (cnt_q < NUM_PIX_C);
        if (last_wr) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Rounding constant is formed at ACC_WIDTH+1 bits, so large shifts drop it.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) rnd = RND_ONE << (shift_q - 5'd1);
    r_sum = $signed({bus.in_acc[ACC_WIDTH-1], bus.in_acc}) + rnd;
    r_shr = r_sum >>> shift_q;
    if (relu_q && r_shr[ACC_WIDTH]) q_val = '0;
    else if (r_shr > SAT_MAX)      q_val = SAT_MAX[DATA_WIDTH-1:0];
    else if (r_shr < SAT_MIN)      q_val = SAT_MIN[DATA_WIDTH-1:0];
    else                           q_val = r_shr[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= accept;
      if (state_q == IDLE && bus.start) begin
        base_q  <= bus.base_addr;
        shift_q <= bus.shift;
        relu_q  <= bus.relu_en;
        cnt_q   <= '0;
      end
      if (accept) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        addr_q  <= base_q + ADDR_BITS'(cnt_q);
        wdata_q <= q_val;
      end
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.sram_write_en = wr_en_q;
  assign bus.sram_addr     = addr_q;
  assign bus.sram_wdata    = wdata_q;
  assign bus.busy          = (state_q == RUN);
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_ofm_wr_ctrl.sv
// tb_ofm_wr_ctrl -- scoreboard bench for ofm_wr_ctrl with a 4-pixel map.
// The driver keeps a map-level model (open map, accepted count, tail cycles)
// and pushes expected writes; a monitor pops them on every SRAM write.
module tb_ofm_wr_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 11;
  localparam int ACCW = 20;
  localparam int NPIX = 4;

  logic clk;
  logic rst;
  ofm_wr_ctrl_if #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .ACC_WIDTH(ACCW)) bus ();

  ofm_wr_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .ACC_WIDTH(ACCW), .NUM_PIX(NPIX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Map-level model state
  bit  m_open = 1'b0;
  int  m_acc  = 0;
  int  m_tail = 0;
  int  m_base = 0;
  int  m_shift = 0;
  bit  m_relu = 1'b0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int quant(int acc, int sh, bit relu);
    longint r;
    r = acc;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r & ((longint'(1) << (ACCW + 1)) - 1);
    if (r >= (longint'(1) << ACCW)) r = r - (longint'(1) << (ACCW + 1));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // One clock: drive inputs at negedge, check status, update model.
  task automatic cyc(bit st, int base, int sh, bit relu, bit vld, int acc, bit ry, bit rs);
    bit exp_done, exp_busy, exp_rdy;
    @(negedge clk);
    rst           = rs;
    bus.start     = st;
    bus.base_addr = AW'(base);
    bus.shift     = 5'(sh);
    bus.relu_en   = relu;
    bus.in_valid  = vld;
    bus.in_acc    = ACCW'(acc);
    bus.sram_ry   = ry;
    #1;
    if (m_open && m_acc == NPIX) begin
      if (m_tail == 0) m_open = 1'b0;
      else m_tail--;
    end
    exp_done = m_open && (m_acc == NPIX) && (m_tail == 0);
    exp_busy = m_open && !exp_done;
    exp_rdy  = m_open && ry && (m_acc < NPIX);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("busy", bus.busy, exp_busy);
    chk("done", bus.done, exp_done);
    if (rs) begin
      m_open = 1'b0;
      m_acc  = 0;
      m_tail = 0;
    end else if (vld && exp_rdy) begin
      exp_q.push_back('{(m_base + m_acc) % (1 << AW), quant(acc, m_shift, m_relu)});
      m_acc++;
      if (m_acc == NPIX) m_tail = 2;
    end else if (st && !m_open) begin
      m_open  = 1'b1;
      m_acc   = 0;
      m_tail  = 0;
      m_base  = base;
      m_shift = sh;
      m_relu  = relu;
    end
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
  endtask

  task automatic run_map(int base, int sh, bit relu, int accs[NPIX], bit rnd_hs,
                         int bp_at, int ign_at, bit st_in_done);
    int k = 0;
    int guard = 0;
    cyc(1'b1, base, sh, relu, 1'b0, 0, 1'b1, 1'b0);
    while (m_acc < NPIX && guard < 200) begin
      bit v  = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
      bit ry = rnd_hs ? ($urandom_range(0, 4) != 0) : 1'b1;
      bit st = 1'b0;
      int b2 = base;
      int s2 = sh;
      if (k >= bp_at && k < bp_at + 3) ry = 1'b0;
      if (k == ign_at) begin
        st = 1'b1;
        b2 = base + 100;
        s2 = (sh + 3) % 32;
      end
      cyc(st, b2, s2, relu, v, accs[m_acc], ry, 1'b0);
      k++;
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      $display("FAIL stream_timeout: accepted %0d required %0d", m_acc, NPIX);
    end
    guard = 0;
    while (m_open && guard < 10) begin
      bit st = st_in_done && (m_acc == NPIX) && (m_tail == 1);
      cyc(st, base + 7, sh, relu, 1'b0, 0, 1'b1, 1'b0);
      guard++;
    end
    if (guard >= 10) begin
      errors++;
      $display("FAIL done_timeout: map still open after %0d cycles, required closed", guard);
    end
    idle_cyc();
  endtask

  function automatic int rand_acc();
    int a;
    case ($urandom_range(0, 2))
      0: a = int'($urandom_range(0, 600)) - 300;
      1: a = int'($urandom_range(0, 10000)) - 5000;
      default: begin
        a = int'($urandom & 32'hFFFFF);
        if (a >= (1 << 19)) a = a - (1 << 20);
      end
    endcase
    return a;
  endfunction

  // Monitor: every SRAM write must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.sram_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_write: addr %0d data %0d, required no write",
                   bus.sram_addr, $signed(bus.sram_wdata));
        end else begin
          e = exp_q.pop_front();
          chk("sram_addr", bus.sram_addr, e.addr);
          chk("sram_wdata", int'($signed(bus.sram_wdata)), e.data);
        end
      end
    end
  end

  initial begin
    int accs[NPIX];
    rst           = 1'b1;
    bus.start     = 1'b1;
    bus.base_addr = '0;
    bus.shift     = '0;
    bus.relu_en   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_acc    = '0;
    bus.sram_ry   = 1'b1;
    repeat (2) @(posedge clk);
    idle_cyc();
    chk("rst_write_en", bus.sram_write_en, 0);
    chk("rst_addr", bus.sram_addr, 0);
    chk("rst_wdata", bus.sram_wdata, 0);

    // Basic map with saturation
    run_map(0, 0, 1'b0, '{5, -3, 200, -200}, 1'b0, 99, 99, 1'b0);
    // Rounding and ReLU
    run_map(0, 4, 1'b1, '{24, 23, -40, 2047}, 1'b0, 99, 99, 1'b0);
    // Backpressure mid-map
    run_map(40, 1, 1'b0, '{7, -7, 9, 300}, 1'b0, 2, 99, 1'b0);
    // Address wrap
    run_map(2046, 0, 1'b0, '{1, 2, 3, 4}, 1'b0, 99, 99, 1'b0);
    // Start ignored while running, and start in the DONE cycle
    run_map(500, 2, 1'b0, '{-9, 10, 11, -12}, 1'b0, 99, 1, 1'b1);
    repeat (3) idle_cyc();

    // Reset mid-map after two accepts, with a third input offered in the reset cycle
    cyc(1'b1, 300, 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 300, 0, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    cyc(1'b0, 300, 0, 1'b0, 1'b1, 12, 1'b1, 1'b0);
    cyc(1'b1, 301, 0, 1'b0, 1'b1, 13, 1'b1, 1'b1);
    idle_cyc();
    chk("midrst_write_en", bus.sram_write_en, 0);
    chk("midrst_addr", bus.sram_addr, 0);
    chk("midrst_wdata", bus.sram_wdata, 0);
    repeat (2) idle_cyc();
    run_map(0, 0, 1'b0, '{21, 22, 23, 24}, 1'b0, 99, 99, 1'b0);

    // Randomised maps
    for (int m = 0; m < 40; m++) begin
      int sh;
      sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10));
      for (int i = 0; i < NPIX; i++) accs[i] = rand_acc();
      run_map(int'($urandom_range(0, (1 << AW) - 1)), sh, 1'($urandom_range(0, 1)), accs,
              1'b1, int'($urandom_range(0, 6)), int'($urandom_range(0, 8)),
              1'($urandom_range(0, 1)));
    end

    repeat (3) idle_cyc();
    chk("pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ofm_wr_ctrl.md
OFM_WR_CTRL -- requirements
Module: ofm_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the quantised output word written to OFM SRAM.
REQ-002 SHALL have parameter ADDR_BITS, default 11: width of the SRAM address (2048 words).
REQ-003 SHALL have parameter ACC_WIDTH, default 20: width of the signed accumulator input.
REQ-004 SHALL have parameter NUM_PIX, default 784: number of output pixels per map (28x28).
REQ-005 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that begins one map.
REQ-008 SHALL have port base_addr, input, ADDR_BITS: first SRAM address of the map, sampled on start.
REQ-009 SHALL have port shift, input, 5: requantisation right-shift, sampled on start.
REQ-010 SHALL have port relu_en, input, 1: enables ReLU, sampled on start.
REQ-011 SHALL have port in_valid, input, 1: in_acc is valid.
REQ-012 SHALL have port in_ready, output, 1: block accepts in_acc this cycle.
REQ-013 SHALL have port in_acc, input, ACC_WIDTH: signed accumulator value.
REQ-014 SHALL have port sram_ry, input, 1: SRAM ready (RY).
REQ-015 SHALL have port sram_write_en, output, 1: 1 = write (active-high; the SRAM wrapper inverts it).
REQ-016 SHALL have port sram_addr, output, ADDR_BITS: SRAM address.
REQ-017 SHALL have port sram_wdata, output, DATA_WIDTH: SRAM write data.
REQ-018 SHALL have port busy, output, 1: high in RUN.
REQ-019 SHALL have port done, output, 1: one-cycle pulse at map completion.

Function
REQ-020 SHALL implement the FSM states IDLE, RUN, and DONE.
- IDLE->RUN on start.
- RUN->DONE on the cycle the NUM_PIX-th write is issued.
- DONE->IDLE unconditionally after 1 cycle.
REQ-021 SHALL ignore start while in RUN or DONE.
REQ-022 SHALL latch base_addr, shift and relu_en on start, and clear the pixel counter to 0.
REQ-023 SHALL drive in_ready = (state==RUN) && sram_ry && (accepted count < NUM_PIX).
REQ-024 SHALL accept one input per cycle, and only when in_valid && in_ready.
REQ-025 SHALL issue exactly one write per accepted input, in the cycle after acceptance (latency 1).
- sram_write_en=1.
- sram_addr = (base_addr + pixel_index) mod 2^ADDR_BITS.
- sram_wdata = quantised value.
REQ-026 SHALL complete a registered write even if sram_ry drops after acceptance.
REQ-027 SHALL compute the quantised value as follows:
- r = in_acc + (shift>0 ? 2^(shift-1) : 0), computed at ACC_WIDTH+1 bits.
- Arithmetic shift r right by shift.
- If relu_en and the result < 0, use 0.
- Saturate to [-128, 127], two's complement.
REQ-028 SHALL wrap sram_addr through 2^ADDR_BITS-1 -> 0 without error.
REQ-029 SHALL hold sram_write_en=0 in every cycle with no accepted input, and keep sram_addr/sram_wdata stable at their last values.
REQ-030 SHALL assert done for exactly one cycle (DONE state), in the cycle after the last write.
REQ-031 SHALL not write to SRAM in IDLE or DONE.
REQ-032 SHALL handle the case where start arrives in the same cycle as done: start is ignored, and a new start is required in IDLE.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, force state=IDLE, counter=0, in_ready=0, sram_write_en=0, busy=0, done=0, sram_addr=0, sram_wdata=0.
REQ-034 SHALL, on reset asserted mid-map, squash any pending write in the next cycle and leave partially written data untouched.
REQ-035 SHALL give rst priority over start in the same cycle.

Verification
REQ-036 SHALL cover a basic map: base_addr=0, shift=0, relu_en=0, NUM_PIX=4, in_acc={5,-3,200,-200} streamed back-to-back.
- Writes occur at addr 0..3 with data {5,-3,127,-128}.
- done pulses 1 cycle after the last write.
REQ-037 SHALL cover rounding and ReLU: shift=4, relu_en=1, in_acc={24,23,-40,2047}.
- Written data = {2,1,0,127} (24+8=32>>4=2; 23+8=31>>4=1).
REQ-038 SHALL cover backpressure: sram_ry=0 for 3 cycles mid-map.
- in_ready=0 during those cycles, with no input loss and no extra writes.
- The address sequence stays contiguous.
REQ-039 SHALL cover address wrap: base_addr=2046, NUM_PIX=4.
- Writes occur at addr 2046, 2047, 0, 1.
REQ-040 SHALL cover reset mid-map: rst after 2 of 4 accepts.
- sram_write_en=0 from the next cycle, state=IDLE, and done is never asserted.
- A following start runs a full map from counter 0.
REQ-041 SHALL cover start ignored: a start pulse in RUN with different base_addr.
- Addresses continue from the original base_addr.
